// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register offsets and TX state encoding shared by TX and RX controllers
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - circular-buffer FIFO with flush; a push into a full FIFO is taken when a pop coincides
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_count;
  logic [AW:0]      rd_count;
  logic             wr_en;
  logic             rd_en;

  assign level = wr_count - rd_count;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_count[AW-1:0]];

  // flush outranks both push and pop in the same cycle
  assign rd_en = pop && !empty && !flush;
  assign wr_en = push && !flush && (!full || rd_en);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (flush) begin
      rd_count <= wr_count;
    end else begin
      if (wr_en) wr_count <= wr_count + 1'b1;
      if (rd_en) rd_count <= rd_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped 8N1 UART transmitter fed from a TX FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wen,
  input  logic        ren,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t        state, state_n;
  logic [BW-1:0]    baud_cnt, baud_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift_reg, shift_n;
  logic             tx_n;
  logic             overflow;

  logic             push_req, flush_req, ovf_clr, status_rd;
  logic             pop, can_pop, baud_last, tx_active;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_level;
  logic [5:0]       level6;
  logic             unused_data;

  assign push_req    = wen && (address == REG_TXDATA);
  assign flush_req   = wen && (address == REG_CTRL) && data_in[0];
  assign ovf_clr     = wen && (address == REG_CTRL) && data_in[1];
  assign status_rd   = ren && (address == REG_STATUS);
  assign unused_data = ^data_in[31:8];

  assign can_pop   = !fifo_empty && !flush_req;
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign tx_active = (state != ST_IDLE);
  assign tx_busy   = tx_active || !fifo_empty;
  assign level6    = 6'(fifo_level);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (pop),
    .flush  (flush_req),
    .wdata  (data_in[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          baud_n  = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          // next byte starts straight after the stop bit, no idle gap
          if (can_pop) begin
            pop     = 1'b1;
            shift_n = fifo_rdata;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // line level is a function of the next state so uart_tx comes straight from a flop
    case (state_n)
      ST_START: tx_n = 1'b0;
      ST_DATA:  tx_n = shift_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      uart_tx   <= tx_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow <= 1'b0;
      data_out <= '0;
    end else begin
      if (push_req && !flush_req && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clr || status_rd)                   overflow <= 1'b0;
      if (ren) begin
        if (address == REG_STATUS)
          data_out <= {22'b0, overflow, tx_active, fifo_full, fifo_empty, level6};
        else
          data_out <= '0;
      end
    end
  end

endmodule
